// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Also used by the existing display driver via hex7_decode.
package seg_pkg;

  typedef enum logic [1:0] {
    PM_LOW  = 2'b00,
    PM_HIGH = 2'b01,
    PM_AUTO = 2'b10
  } page_mode_e;

  typedef logic [1:0] digit_t;

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Valid/ready handshake carrying the 32-bit display value
// from the core into the scan controller.
interface seg_scan_ctrl_if;
  logic        data_valid;
  logic [31:0] data_in;
  logic        data_ready;

  modport master (
    output data_valid,
    output data_in,
    input  data_ready
  );

  modport slave (
    input  data_valid,
    input  data_in,
    output data_ready
  );
endinterface

// File: rtl/seg_scan_ctrl_hex7_decode.sv
// Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
// Pure combinational; shared with the legacy display driver.
module hex7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode scan scheduler: prescaled slots, frame-
// aligned data swap, page select, duty dimming, zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int PAGE_HOLD = 2048
) (
  input  logic            clk,
  input  logic            rst,
  seg_scan_ctrl_if.slave  bus,
  input  logic [1:0]      page_mode,
  input  logic [2:0]      bright,
  input  logic            blank_lz,
  output logic [3:0]      anode,
  output logic [6:0]      seg,
  output logic            page
);

  localparam int PCW = $clog2(SCAN_DIV);
  localparam int FCW =
    (PAGE_HOLD > 1) ? $clog2(PAGE_HOLD) : 1;

  logic [PCW-1:0] pc;
  digit_t         digit;
  logic [FCW-1:0] fcnt;
  logic [31:0]    stage;
  logic [31:0]    disp;
  logic           stage_full;
  logic           page_r;

  logic        tick;
  logic        boundary;
  logic        accept;
  logic [15:0] half;
  logic [15:0] upper;
  logic [31:0] on_len;
  logic        blank;
  logic        lit;
  logic [6:0]  seg_d;
  logic [3:0]  anode_d;

  assign tick     = (pc == PCW'(SCAN_DIV - 1));
  assign boundary = tick && (digit == 2'd3);
  assign accept   = bus.data_valid && !stage_full;

  assign bus.data_ready = !stage_full;

  assign half  = page_r ? disp[31:16] : disp[15:0];
  assign upper = half >> {digit, 2'b00};

  // Digit and every higher nibble zero => leading zero
  assign blank = blank_lz && (digit != 2'd0)
              && (upper == 16'd0);

  assign on_len = ((32'(bright) + 32'd1)
                * 32'(SCAN_DIV)) >> 3;

  assign lit     = (32'(pc) < on_len) && !blank;
  assign anode_d = lit ? ~(4'b0001 << digit)
                       : ANODE_OFF;

  hex7_decode u_dec (
    .nib (upper[3:0]),
    .seg (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      digit      <= '0;
      fcnt       <= '0;
      stage      <= '0;
      disp       <= '0;
      stage_full <= 1'b0;
      page_r     <= 1'b0;
      anode      <= ANODE_OFF;
      seg        <= SEG_BLANK;
      page       <= 1'b0;
    end else begin
      pc <= tick ? '0 : pc + PCW'(1);
      if (tick)
        digit <= digit + 2'd1;

      // Swap only at frame end so a frame never mixes values
      if (boundary && stage_full) begin
        disp       <= stage;
        stage_full <= 1'b0;
      end else if (accept) begin
        stage      <= bus.data_in;
        stage_full <= 1'b1;
      end

      if (boundary) begin
        case (page_mode)
          PM_HIGH: begin
            page_r <= 1'b1;
            fcnt   <= '0;
          end
          PM_AUTO: begin
            if (fcnt == FCW'(PAGE_HOLD - 1)) begin
              page_r <= ~page_r;
              fcnt   <= '0;
            end else begin
              fcnt <= fcnt + FCW'(1);
            end
          end
          default: begin
            page_r <= 1'b0;
            fcnt   <= '0;
          end
        endcase
      end

      anode <= anode_d;
      seg   <= lit ? seg_d : SEG_BLANK;
      page  <= page_r;
    end
  end

endmodule
